hazard_control_unit: RTL



---
 rtl/hazard_control_unit_pkg.sv | 18 +
 rtl/hazard_control_unit_if.sv | 40 ++++
 rtl/hazard_control_unit_sat.sv | 30 +++
 rtl/hazard_control_unit.sv | 98 +++++++++
 4 files changed

// File: rtl/hazard_control_unit_pkg.sv
// Shared opcodes, register-address width and memory-handshake state encoding
// for the hazard controller.
package hazard_control_unit_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-side view of the hazard controller: stage opcodes/registers in,
// stall/flush/bubble controls and performance counters out.
interface hazard_control_unit_if
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int CNT_WIDTH      = 16
);
    logic [6:0]                IF_ID_inst_opcode;
    logic [REG_ADDR_WIDTH-1:0] IF_ID_rs1;
    logic [REG_ADDR_WIDTH-1:0] IF_ID_rs2;
    logic [6:0]                ID_EX_inst_opcode;
    logic [REG_ADDR_WIDTH-1:0] ID_EX_rd;
    logic [6:0]                EX_MEM_inst_opcode;
    logic                      branch_taken;
    logic                      dmem_ready;
    logic                      dmem_req;
    logic                      pc_wr_en;
    logic                      IF_ID_wr_en;
    logic                      IF_ID_flush;
    logic                      ID_EX_bubble;
    logic                      EX_MEM_hold;
    logic                      MEM_WB_bubble;
    logic [CNT_WIDTH-1:0]      stall_count;
    logic [CNT_WIDTH-1:0]      flush_count;

    modport master (
        output IF_ID_inst_opcode, IF_ID_rs1, IF_ID_rs2, ID_EX_inst_opcode, ID_EX_rd,
               EX_MEM_inst_opcode, branch_taken, dmem_ready,
        input  dmem_req, pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_bubble,
               EX_MEM_hold, MEM_WB_bubble, stall_count, flush_count
    );

    modport slave (
        input  IF_ID_inst_opcode, IF_ID_rs1, IF_ID_rs2, ID_EX_inst_opcode, ID_EX_rd,
               EX_MEM_inst_opcode, branch_taken, dmem_ready,
        output dmem_req, pc_wr_en, IF_ID_wr_en, IF_ID_flush, ID_EX_bubble,
               EX_MEM_hold, MEM_WB_bubble, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_control_unit_sat.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
// Count is visible the edge after the qualifying cycle.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_control_unit.sv
// Load-use bubble insertion, ID-stage redirect flush and data-memory freeze.
// Controls are combinational from inputs and FSM state; counters lag one edge.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = REG_ADDR_W,
    parameter int CNT_WIDTH      = 16
) (
    input  logic clk,
    input  logic rst_n,
    hazard_control_unit_if.slave hif
);
    localparam logic [REG_ADDR_WIDTH-1:0] REG_X0 = '0;

    mem_state_e state_q;
    mem_state_e state_d;
    logic       mem_op;
    logic       load_use;
    logic       redirect;
    logic       freeze;

    assign mem_op = (hif.EX_MEM_inst_opcode == OP_LW) || (hif.EX_MEM_inst_opcode == OP_SW);

    // rs2 is compared even for formats without rs2: a spurious bubble is harmless.
    assign load_use = (hif.ID_EX_inst_opcode == OP_LW) && (hif.ID_EX_rd != REG_X0) &&
                      ((hif.ID_EX_rd == hif.IF_ID_rs1) || (hif.ID_EX_rd == hif.IF_ID_rs2));

    assign redirect = ((hif.IF_ID_inst_opcode == OP_BEQ) && hif.branch_taken) ||
                      (hif.IF_ID_inst_opcode == OP_JAL) || (hif.IF_ID_inst_opcode == OP_JALR);

    always_comb begin
        state_d      = state_q;
        hif.dmem_req = 1'b0;
        freeze       = 1'b0;
        case (state_q)
            M_IDLE: begin
                hif.dmem_req = mem_op;
                if (mem_op && !hif.dmem_ready) begin
                    state_d = M_WAIT;
                    freeze  = 1'b1;
                end
            end
            M_WAIT: begin
                hif.dmem_req = 1'b1;
                if (hif.dmem_ready) begin
                    state_d = M_IDLE;
                end else begin
                    freeze = 1'b1;
                end
            end
            default: state_d = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= M_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        hif.pc_wr_en      = 1'b1;
        hif.IF_ID_wr_en   = 1'b1;
        hif.IF_ID_flush   = 1'b0;
        hif.ID_EX_bubble  = 1'b0;
        hif.EX_MEM_hold   = 1'b0;
        hif.MEM_WB_bubble = 1'b0;
        if (freeze) begin
            hif.pc_wr_en      = 1'b0;
            hif.IF_ID_wr_en   = 1'b0;
            hif.EX_MEM_hold   = 1'b1;
            hif.MEM_WB_bubble = 1'b1;
        end else if (load_use) begin
            // A taken branch waiting on the load re-resolves after the bubble.
            hif.pc_wr_en     = 1'b0;
            hif.IF_ID_wr_en  = 1'b0;
            hif.ID_EX_bubble = 1'b1;
        end else if (redirect) begin
            hif.IF_ID_flush = 1'b1;
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (freeze || load_use),
        .count (hif.stall_count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hif.IF_ID_flush),
        .count (hif.flush_count)
    );
endmodule
